wb_timeout: RTL and testbench

- Single-clock Wishbone guard stage placed directly downstream of the clock-domain-crossing register, between its slave-side port and the target slave.
- Passes cycles through combinationally and counts wait cycles.
- If the slave does not terminate a strobed cycle within TIMEOUT clocks, aborts it toward the slave and returns ERR to the master, so a dead slave never hangs the crossing.
- Keeps a sticky timeout flag and a saturating timeout event counter for status readback.

---
 rtl/wb_timeout.sv | 119 +++++++++++
 tb/tb_wb_timeout.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timeout.sv
// Wishbone guard stage: zero-latency pass-through that aborts a strobed cycle the
// slave leaves unterminated for TIMEOUT clocks, and returns ERR to the master.
module wb_timeout #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,
  input  logic                    clear_i,
  output logic                    timeout_flag,
  output logic [CNT_WIDTH-1:0]    timeout_count
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_ABORT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic                 flag_q, flag_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 term;
  logic                 abort;
  logic                 gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PASS;
      wcnt_q  <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  // Wait counting, abort decision and status bookkeeping
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    flag_d  = flag_q;
    count_d = count_q;
    term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    case (state_q)
      ST_PASS: begin
        if (clear_i) begin
          flag_d  = 1'b0;
          count_d = '0;
        end
        if (wbm_cyc_i && wbm_stb_i && !term) begin
          if (wcnt_q == WCNT_LAST) begin
            state_d = ST_ABORT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_PASS;
        flag_d  = 1'b1;
        if (clear_i) begin
          count_d = CNT_WIDTH'(1);
        end else if (count_q != {CNT_WIDTH{1'b1}}) begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  // Forwarding; reset and the abort cycle both kill the control strobes
  always_comb begin
    abort     = (state_q == ST_ABORT);
    gate      = rst | abort;
    wbs_adr_o = wbm_adr_i;
    wbs_dat_o = wbm_dat_i;
    wbs_sel_o = wbm_sel_i;
    wbs_cyc_o = wbm_cyc_i & ~gate;
    wbs_stb_o = wbm_stb_i & ~gate;
    wbs_we_o  = wbm_we_i & ~gate;
    wbm_ack_o = wbs_ack_i & ~gate;
    wbm_rty_o = wbs_rty_i & ~gate;
    wbm_err_o = ~rst & (abort | wbs_err_i);
    wbm_dat_o = gate ? '0 : wbs_dat_i;
  end

  assign timeout_flag  = flag_q;
  assign timeout_count = count_q;

endmodule

// File: tb/tb_wb_timeout.sv
// Bench for wb_timeout: constant vector table, directed timeout/reset sequences and
// random traffic, all checked against a run-length reference model.
module tb_wb_timeout;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned TO  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wbm_adr_i;
  logic [DW-1:0] wbm_dat_i, wbm_dat_o;
  logic          wbm_we_i;
  logic [SW-1:0] wbm_sel_i;
  logic          wbm_stb_i, wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_cyc_i;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_i, wbs_dat_o;
  logic          wbs_we_o;
  logic [SW-1:0] wbs_sel_o;
  logic          wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_cyc_o;
  logic          clear_i;
  logic          timeout_flag;
  logic [CW-1:0] timeout_count;

  // Second instance only for counter saturation
  logic [DW-1:0]  s_mdat, s_sdat;
  logic [AW-1:0]  s_adr;
  logic [SW-1:0]  s_sel;
  logic           s_ack, s_err, s_rty, s_we, s_stb, s_cyc, s_flag;
  logic [CW2-1:0] s_count;

  always #5 clk = ~clk;

  wb_timeout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o), .wbm_we_i(wbm_we_i),
    .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o), .wbm_cyc_i(wbm_cyc_i),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i), .wbs_cyc_o(wbs_cyc_o),
    .clear_i(clear_i), .timeout_flag(timeout_flag), .timeout_count(timeout_count)
  );

  wb_timeout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO), .CNT_WIDTH(CW2)) dut_sat (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(s_mdat), .wbm_we_i(wbm_we_i),
    .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i), .wbm_ack_o(s_ack), .wbm_err_o(s_err),
    .wbm_rty_o(s_rty), .wbm_cyc_i(wbm_cyc_i),
    .wbs_adr_o(s_adr), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(s_sdat), .wbs_we_o(s_we),
    .wbs_sel_o(s_sel), .wbs_stb_o(s_stb), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i), .wbs_cyc_o(s_cyc),
    .clear_i(clear_i), .timeout_flag(s_flag), .timeout_count(s_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: length of the current stalled run, pending abort, timeouts since clear
  int run    = 0;
  bit m_abt  = 1'b0;
  bit m_flag = 1'b0;
  int events = 0;

  typedef struct {
    logic        cyc, stb, ack, err, rty;
    logic [31:0] sdat;
    logic        e_ack, e_err, e_rty, e_scyc, e_sstb;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic c, input logic s, input logic a, input logic e, input logic r,
                     input logic [31:0] sd);
    wbm_cyc_i = c;
    wbm_stb_i = s;
    wbs_ack_i = a;
    wbs_err_i = e;
    wbs_rty_i = r;
    wbs_dat_i = sd;
    wbm_adr_i = $urandom;
    wbm_dat_i = $urandom;
    wbm_we_i  = 1'($urandom);
    wbm_sel_i = 4'($urandom);
  endtask

  // Mid-cycle comparison of every output against the model
  task automatic sample();
    logic        g;
    logic [15:0] e16;
    logic [1:0]  e2;
    #3;
    g   = rst | m_abt;
    e16 = rst ? 16'd0 : ((events > 65535) ? 16'hFFFF : 16'(events));
    e2  = rst ? 2'd0 : ((events > 3) ? 2'd3 : 2'(events));
    chk("ack", wbm_ack_o, wbs_ack_i & ~g);
    chk("err", wbm_err_o, ~rst & (m_abt | wbs_err_i));
    chk("rty", wbm_rty_o, wbs_rty_i & ~g);
    chk("mdat", wbm_dat_o, g ? 32'd0 : wbs_dat_i);
    chk("scyc", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, g ? 3'b000 : {wbm_cyc_i, wbm_stb_i, wbm_we_i});
    chk("fwd", {wbs_adr_o, wbs_dat_o, wbs_sel_o}, {wbm_adr_i, wbm_dat_i, wbm_sel_i});
    chk("flag", {timeout_flag, s_flag}, rst ? 2'b00 : {m_flag, m_flag});
    chk("count", timeout_count, e16);
    chk("count_sat", s_count, e2);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      run = 0; m_abt = 1'b0; m_flag = 1'b0; events = 0;
    end else if (m_abt) begin
      m_abt  = 1'b0;
      run    = 0;
      m_flag = 1'b1;
      events = clear_i ? 1 : events + 1;
    end else begin
      if (clear_i) begin
        m_flag = 1'b0;
        events = 0;
      end
      if (wbm_cyc_i && wbm_stb_i && !(wbs_ack_i || wbs_err_i || wbs_rty_i)) begin
        run++;
        if (run == TO) begin
          m_abt = 1'b1;
          run   = 0;
        end
      end else begin
        run = 0;
      end
    end
    #1;
  endtask

  task automatic cyc_step(input logic c, input logic s, input logic a, input logic [31:0] sd);
    drv(c, s, a, 1'b0, 1'b0, sd);
    sample();
    advance();
  endtask

  // TO silent strobed cycles followed by the abort cycle (with optional clear)
  task automatic do_timeout(input logic clr);
    for (int i = 0; i < int'(TO); i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    clear_i = clr;
    sample();
    chk("abort_err", wbm_err_o, 1'b1);
    advance();
    clear_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 0, 0, 32'h1234_5678, 1, 0, 0, 1, 1, 32'h1234_5678};
    tbl[1] = '{1, 1, 0, 1, 0, 32'hCAFE_F00D, 0, 1, 0, 1, 1, 32'hCAFE_F00D};
    tbl[2] = '{1, 1, 0, 0, 1, 32'h0000_00FF, 0, 0, 1, 1, 1, 32'h0000_00FF};
    tbl[3] = '{1, 0, 0, 0, 0, 32'hA5A5_A5A5, 0, 0, 0, 1, 0, 32'hA5A5_A5A5};
    tbl[4] = '{0, 1, 1, 0, 0, 32'h5A5A_5A5A, 1, 0, 0, 0, 1, 32'h5A5A_5A5A};
    tbl[5] = '{1, 1, 0, 0, 0, 32'h0F0F_0F0F, 0, 0, 0, 1, 1, 32'h0F0F_0F0F};

    // Reset state
    rst = 1'b1; clear_i = 1'b0;
    drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    sample();
    chk("rst_gate", {wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o}, 4'b0000);
    chk("rst_status", {timeout_flag, timeout_count}, 17'd0);
    advance();
    rst = 1'b0;
    cyc_step(1'b0, 1'b0, 1'b0, 32'h0);

    // Pass-through vector table
    for (int i = 0; i < 6; i++) begin
      drv(tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].err, tbl[i].rty, tbl[i].sdat);
      sample();
      chk($sformatf("vec%0d_resp", i), {wbm_ack_o, wbm_err_o, wbm_rty_o},
          {tbl[i].e_ack, tbl[i].e_err, tbl[i].e_rty});
      chk($sformatf("vec%0d_ctl", i), {wbs_cyc_o, wbs_stb_o}, {tbl[i].e_scyc, tbl[i].e_sstb});
      chk($sformatf("vec%0d_dat", i), wbm_dat_o, tbl[i].e_dat);
      advance();
    end
    cyc_step(1'b0, 1'b0, 1'b0, 32'h0);

    // Read acked 3 cycles after stb
    for (int i = 0; i < 3; i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    sample();
    chk("rd_ack", {wbm_ack_o, wbm_err_o}, 2'b10);
    chk("rd_dat", wbm_dat_o, 32'hDEAD_BEEF);
    advance();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("rd_flag", timeout_flag, 1'b0);
    advance();

    // Silent slave: err exactly at cycle TO, one cycle long
    for (int i = 0; i < int'(TO); i++) begin
      drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      sample();
      chk("to_early_err", wbm_err_o, 1'b0);
      advance();
    end
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("to_err", wbm_err_o, 1'b1);
    chk("to_cyc_low", wbs_cyc_o, 1'b0);
    advance();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("to_err_once", wbm_err_o, 1'b0);
    chk("to_status", {timeout_flag, timeout_count}, {1'b1, 16'd1});
    advance();

    // Ack at wcnt == TO-1 wins over the abort
    for (int i = 0; i < int'(TO) - 1; i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1111_2222);
    sample();
    chk("late_ack", {wbm_ack_o, wbm_err_o}, 2'b10);
    advance();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("late_ack_cnt", timeout_count, 16'd1);
    advance();

    // Ack landing in the abort cycle is swallowed
    for (int i = 0; i < int'(TO); i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3333_4444);
    sample();
    chk("abort_ack", {wbm_ack_o, wbm_err_o}, 2'b01);
    advance();
    cyc_step(1'b0, 1'b0, 1'b0, 32'h0);

    // Stb dropped at cycle 5, restarted at 6, acked at 12
    for (int i = 0; i < 5; i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    cyc_step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 6; i < 12; i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("restart_ack", {wbm_ack_o, wbm_err_o}, 2'b10);
    advance();

    // Clear, three timeouts, clear coinciding with a fourth, then saturation
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    clear_i = 1'b1;
    sample();
    advance();
    clear_i = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("clr_status", {timeout_flag, timeout_count}, 17'd0);
    advance();
    for (int i = 0; i < 3; i++) do_timeout(1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("cnt3", {timeout_count, s_count}, {16'd3, 2'd3});
    advance();
    do_timeout(1'b1);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("clr_abort", {timeout_flag, timeout_count, s_count}, {1'b1, 16'd1, 2'd1});
    advance();
    for (int i = 0; i < 5; i++) do_timeout(1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("sat", {timeout_count, s_count}, {16'd6, 2'd3});
    advance();

    // Reset at cycle 4 of a wait
    for (int i = 0; i < 4; i++) cyc_step(1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    sample();
    chk("rst_mid_cyc", wbs_cyc_o, 1'b0);
    chk("rst_mid_status", {timeout_flag, timeout_count}, 17'd0);
    advance();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      sample();
      chk("rst_no_err", wbm_err_o, 1'b0);
      advance();
    end
    cyc_step(1'b1, 1'b1, 1'b1, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      drv(($urandom % 8) != 0, ($urandom % 5) != 0, ($urandom % 12) == 0,
          ($urandom % 40) == 0, ($urandom % 40) == 0, $urandom);
      clear_i = (($urandom % 60) == 0);
      rst     = (($urandom % 300) == 0);
      sample();
      advance();
    end
    rst = 1'b0; clear_i = 1'b0;
    cyc_step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
